// File: rtl/alu_muldiv_pkg.sv
// alu_muldiv_pkg
//   Shared definitions for the iterative multiply/divide unit:
//   - opsel codes of the multi-cycle ALU operations (same values the
//     controlUnit / opsel decode drives)
//   - FSM state encoding and the latched operation kind
//   - flag bit positions inside the 4-bit {ZF,NF,CF,OF} vector
//   - helper that recognises a multi-cycle opsel
package alu_muldiv_pkg;

  localparam int OPSEL_W = 5;

  localparam logic [OPSEL_W-1:0] ALU_MUL = 5'h10;
  localparam logic [OPSEL_W-1:0] ALU_DIV = 5'h11;
  localparam logic [OPSEL_W-1:0] ALU_MOD = 5'h12;

  localparam int FLAG_ZF = 3;
  localparam int FLAG_NF = 2;
  localparam int FLAG_CF = 1;
  localparam int FLAG_OF = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_DIV = 2'd1,
    OP_MOD = 2'd2
  } op_kind_t;

  function automatic logic is_muldiv_op(input logic [OPSEL_W-1:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
//   One combinational iteration of the shared multiply/divide datapath.
//   The working state is a pair of WIDTH-bit registers {hi, lo}:
//   - multiply: {hi, lo} is the partial product, lo starts as the multiplier
//     and is consumed LSB-first; opnd is the multiplicand.
//   - divide:   hi is the partial remainder, lo starts as the dividend and
//     fills up with quotient bits from the right; opnd is the divisor.
// Ports:
//   is_mul   - 1 selects the multiply step, 0 the restoring-divide step
//   hi, lo   - current working registers
//   opnd     - latched multiplicand / divisor
//   hi_next, lo_next - working registers after this iteration
module muldiv_step #(
  parameter int WIDTH = 16
) (
  input  logic             is_mul,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shifted;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;

  always_comb begin
    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the whole {carry, hi, lo} right by one.
    mul_sum = lo[0] ? ({1'b0, hi} + {1'b0, opnd}) : {1'b0, hi};

    // Divide: bring the next dividend bit into the remainder and try the
    // subtraction. The remainder is always below the divisor before the
    // shift, so a successful difference fits in WIDTH bits. With a zero
    // divisor every trial succeeds, giving an all-ones quotient and the
    // dividend as remainder without any special casing.
    div_shifted = {hi, lo[WIDTH-1]};
    div_ge      = (div_shifted >= {1'b0, opnd});
    div_rem     = div_ge ? (div_shifted[WIDTH-1:0] - opnd) : div_shifted[WIDTH-1:0];

    if (is_mul) begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo[WIDTH-1:1]};
    end else begin
      hi_next = div_rem;
      lo_next = {lo[WIDTH-2:0], div_ge};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv
//   Iterative multiply / divide / modulo unit answering the opsel/ready
//   handshake of controlUnit. A multi-cycle opsel seen in IDLE is latched,
//   WIDTH iterations run in BUSY, and the registered result is presented
//   for one cycle in DONE. ready is held low from the issue cycle until
//   DONE so the PC and register writes stall.
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous reset, active low
//   opsel  - ALU operation select (only MUL/DIV/MOD start this unit)
//   srcA   - operand A (multiplicand / dividend)
//   srcB   - operand B (multiplier / divisor)
//   result - registered result, valid while done = 1
//   flags  - registered {ZF,NF,CF,OF}, valid while done = 1
//   done   - one-cycle pulse marking a valid result
//   ready  - combinational handshake back to controlUnit
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPSEL_W-1:0] opsel,
  input  logic [WIDTH-1:0]   srcA,
  input  logic [WIDTH-1:0]   srcB,
  output logic [WIDTH-1:0]   result,
  output logic [3:0]         flags,
  output logic               done,
  output logic               ready
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  op_kind_t         op_reg, op_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [WIDTH-1:0] opnd_reg, opnd_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [3:0]       flags_reg, flags_next;
  logic             done_reg, done_next;

  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] final_res;
  logic             final_cf, final_of;
  logic             issue_op;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_mul  (op_reg == OP_MUL),
    .hi      (hi_reg),
    .lo      (lo_reg),
    .opnd    (opnd_reg),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  assign issue_op = is_muldiv_op(opsel);

  // While in reset the unit is treated as idle, so single-cycle ops are not
  // stalled by a reset that happens to coincide with them.
  always_comb begin
    if (!rst) begin
      ready = !issue_op;
    end else begin
      ready = (state_reg == ST_DONE) || ((state_reg == ST_IDLE) && !issue_op);
    end
  end

  // Result selection for the final iteration, taken from the step outputs so
  // result/flags are registered on the same edge that enters DONE.
  always_comb begin
    final_res = step_lo;
    final_cf  = 1'b0;
    final_of  = 1'b0;
    case (op_reg)
      OP_MUL: begin
        final_res = step_lo;
        final_cf  = |step_hi;
        final_of  = |step_hi;
      end
      OP_DIV: begin
        final_res = step_lo;
        final_of  = (opnd_reg == '0);
      end
      OP_MOD: begin
        final_res = step_hi;
        final_of  = (opnd_reg == '0);
      end
      default: begin
        final_res = step_lo;
      end
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    count_next  = count_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    opnd_next   = opnd_reg;
    result_next = result_reg;
    flags_next  = flags_reg;
    done_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (issue_op) begin
          state_next = ST_BUSY;
          count_next = '0;
          hi_next    = '0;
          // Multiply iterates over B and adds A; divide shifts A out and
          // compares against B.
          if (opsel == ALU_MUL) begin
            op_next   = OP_MUL;
            opnd_next = srcA;
            lo_next   = srcB;
          end else begin
            op_next   = (opsel == ALU_DIV) ? OP_DIV : OP_MOD;
            opnd_next = srcB;
            lo_next   = srcA;
          end
        end
      end
      ST_BUSY: begin
        hi_next    = step_hi;
        lo_next    = step_lo;
        count_next = count_reg + 1'b1;
        if (count_reg == LAST_ITER) begin
          state_next           = ST_DONE;
          done_next            = 1'b1;
          result_next          = final_res;
          flags_next[FLAG_ZF]  = (final_res == '0);
          flags_next[FLAG_NF]  = final_res[WIDTH-1];
          flags_next[FLAG_CF]  = final_cf;
          flags_next[FLAG_OF]  = final_of;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      op_reg     <= OP_MUL;
      count_reg  <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      opnd_reg   <= '0;
      result_reg <= '0;
      flags_reg  <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      count_reg  <= count_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      opnd_reg   <= opnd_next;
      result_reg <= result_next;
      flags_reg  <= flags_next;
      done_reg   <= done_next;
    end
  end

  assign result = result_reg;
  assign flags  = flags_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv
//   Directed, table-driven bench for alu_muldiv (WIDTH = 16). Each vector
//   issues one multi-cycle op, counts the ready-low cycles, and checks
//   result/flags in the DONE cycle against hand-computed values. Extra
//   sequences cover reset behaviour, single-cycle opsel pass-through,
//   back-to-back issue and reset in the middle of BUSY.
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  localparam int W = 16;
  localparam logic [4:0] ALU_ADD = 5'h00;

  logic         clk;
  logic         rst;
  logic [4:0]   opsel;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         done;
  logic         ready;

  int n_cmp;
  int n_fail;

  alu_muldiv #(
    .WIDTH(W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .opsel  (opsel),
    .srcA   (srcA),
    .srcB   (srcB),
    .result (result),
    .flags  (flags),
    .done   (done),
    .ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flg;      // {ZF,NF,CF,OF}
    logic [4:0]   next_op;  // opsel presented in the DONE cycle
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called in an IDLE cycle (time = posedge + 1). Returns in the cycle after
  // DONE, with opsel = next_op.
  task automatic run_op(input string name, input logic [4:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input logic [3:0] exp_flg,
                        input logic [4:0] next_op);
    int low;
    opsel = op;
    srcA  = a;
    srcB  = b;
    #1;
    low = 0;
    while (ready == 1'b0 && low < 40) begin
      low++;
      @(posedge clk);
      #1;
      if (low == 1) begin
        // Operands and op must already be latched.
        srcA  = ~a;
        srcB  = ~b;
        opsel = ALU_ADD;
      end
    end
    check({name, " ready_low_cycles"}, low, 17);
    check({name, " done"}, {31'd0, done}, 1);
    check({name, " result"}, {16'd0, result}, {16'd0, exp_res});
    check({name, " flags"}, {28'd0, flags}, {28'd0, exp_flg});
    $display("%s: op=0x%0h a=0x%04h b=0x%04h -> result=0x%04h flags=%b (%0d stall cycles)",
             name, op, a, b, result, flags, low);
    opsel = next_op;
    srcA  = a;
    srcB  = b;
    @(posedge clk);
    #1;
    check({name, " done_one_cycle"}, {31'd0, done}, 0);
    if (is_muldiv_op(next_op)) begin
      check({name, " back_to_back_issue"}, {31'd0, ready}, 0);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b0;
    opsel  = ALU_ADD;
    srcA   = '0;
    srcB   = '0;

    vecs[0]  = '{ALU_MUL, 16'd300,   16'd7,     16'h0834, 4'b0000, ALU_ADD};
    vecs[1]  = '{ALU_MUL, 16'h1234,  16'h0100,  16'h3400, 4'b0011, ALU_ADD};
    vecs[2]  = '{ALU_DIV, 16'd100,   16'd7,     16'd14,   4'b0000, ALU_MOD};
    vecs[3]  = '{ALU_MOD, 16'd100,   16'd7,     16'd2,    4'b0000, ALU_ADD};
    vecs[4]  = '{ALU_DIV, 16'h8001,  16'h0000,  16'hFFFF, 4'b0101, ALU_MOD};
    vecs[5]  = '{ALU_MOD, 16'h8001,  16'h0000,  16'h8001, 4'b0101, ALU_ADD};
    vecs[6]  = '{ALU_MUL, 16'hFFFF,  16'hFFFF,  16'h0001, 4'b0011, ALU_ADD};
    vecs[7]  = '{ALU_MUL, 16'h0000,  16'd5,     16'h0000, 4'b1000, ALU_ADD};
    vecs[8]  = '{ALU_DIV, 16'd5,     16'd9,     16'h0000, 4'b1000, ALU_ADD};
    vecs[9]  = '{ALU_MOD, 16'hFFFF,  16'h0010,  16'h000F, 4'b0000, ALU_ADD};
    vecs[10] = '{ALU_DIV, 16'hFFFF,  16'h0001,  16'hFFFF, 4'b0100, ALU_ADD};
    vecs[11] = '{ALU_MUL, 16'h0100,  16'h0080,  16'h8000, 4'b0100, ALU_ADD};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset result", {16'd0, result}, 0);
    check("reset flags", {28'd0, flags}, 0);
    check("reset done", {31'd0, done}, 0);
    check("reset ready add", {31'd0, ready}, 1);
    opsel = ALU_MUL;
    #1;
    check("reset ready mul", {31'd0, ready}, 0);
    opsel = ALU_ADD;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single-cycle op held: never stalls, never starts the unit.
    for (int i = 0; i < 10; i++) begin
      check($sformatf("add hold ready c%0d", i), {31'd0, ready}, 1);
      check($sformatf("add hold done c%0d", i), {31'd0, done}, 0);
      @(posedge clk);
      #1;
    end
    $display("add hold: 10 cycles checked");

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].flg, vecs[i].next_op);
    end

    // Reset during BUSY cycle 8 of MUL 5x5.
    opsel = ALU_MUL;
    srcA  = 16'd5;
    srcB  = 16'd5;
    @(posedge clk);
    #1;
    repeat (7) @(posedge clk);
    #1;
    check("midbusy ready", {31'd0, ready}, 0);
    rst   = 1'b0;
    opsel = ALU_ADD;
    @(posedge clk);
    #1;
    check("midbusy rst result", {16'd0, result}, 0);
    check("midbusy rst flags", {28'd0, flags}, 0);
    check("midbusy rst done", {31'd0, done}, 0);
    check("midbusy rst ready", {31'd0, ready}, 1);
    rst = 1'b1;
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 24; i++) begin
        @(posedge clk);
        #1;
        if (done) pulses++;
      end
      check("midbusy no done pulse", pulses, 0);
    end
    $display("midbusy reset: partial MUL discarded");
    run_op("mul after reset", ALU_MUL, 16'd5, 16'd5, 16'd25, 4'b0000, ALU_ADD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
